coso_count_ctrl: RTL and testbench

Sequencing controller for the COSO TRNG ripple counter. It runs one measurement per request:
- clears the counter;
- enables it for exactly one beat period of the synchronised beat signal;
- waits for the ripple chain to settle, then captures the count;
- hands the count and its LSB (raw random bit) downstream over a valid/ready handshake.

It sits between the oscillator-sampling flop/counter pair and the post-processing/readout logic, all in the system clock domain.

---
 rtl/coso_count_ctrl.sv | 164 ++++++++++++++++
 tb/tb_coso_count_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/coso_count_ctrl.sv
// COSO TRNG ripple-counter sequencer: clear, count one beat period, settle, capture, hand off.
// Optional abort timer in ARM/COUNT is built when COSO_TIMEOUT_EN is defined.
module coso_count_ctrl #(
    parameter int unsigned width         = 16,
    parameter int unsigned settleCycles  = 4,
    parameter int unsigned timeoutCycles = 65535
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             beat,
    input  logic [width-1:0] cnt,
    output logic             cntClr,
    output logic             cntEn,
    output logic             busy,
    output logic             sampleValid,
    input  logic             sampleReady,
    output logic [width-1:0] sample,
    output logic             rndBit,
    output logic             timeoutErr
);

    // state   | meaning
    // IDLE    | waiting for start
    // CLEAR   | counter held in clear for two cycles
    // ARM     | waiting for a fresh beat rising edge
    // COUNT   | counter enabled until the next beat rising edge
    // SETTLE  | ripple chain settling, settleCycles cycles
    // CAPTURE | load output register once it is free
    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ARM,
        S_COUNT,
        S_SETTLE,
        S_CAPTURE
    } state_t;

    localparam logic [7:0] SETTLE_LOAD = 8'(settleCycles - 1);

    state_t           state_q, state_d;
    logic             beat_meta_q, beat_sync_q, beat_prev_q;
    logic             beat_rise;
    logic             clr_cnt_q, clr_cnt_d;
    logic [7:0]       settle_q, settle_d;
    logic [width-1:0] sample_q;
    logic             valid_q;
    logic             capture;

    assign beat_rise = beat_sync_q & ~beat_prev_q;

`ifdef COSO_TIMEOUT_EN
    localparam logic [19:0] TMO_LOAD = 20'(timeoutCycles - 1);
    logic [19:0] tmo_q, tmo_d;
    logic        tmo_err_q, tmo_err_d;
`endif

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        settle_d  = settle_q;
        capture   = 1'b0;
        cntClr    = 1'b0;
        cntEn     = 1'b0;
        busy      = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_CLEAR;
                    clr_cnt_d = 1'b0;
                end
            end
            S_CLEAR: begin
                cntClr    = 1'b1;
                clr_cnt_d = ~clr_cnt_q;
                if (clr_cnt_q) state_d = S_ARM;
            end
            S_ARM: begin
                if (beat_rise) state_d = S_COUNT;
            end
            S_COUNT: begin
                cntEn = 1'b1;
                if (beat_rise) begin
                    state_d  = S_SETTLE;
                    settle_d = SETTLE_LOAD;
                end
            end
            S_SETTLE: begin
                if (settle_q == 8'd0) state_d = S_CAPTURE;
                else                  settle_d = settle_q - 8'd1;
            end
            S_CAPTURE: begin
                // A held sample may be replaced on the edge it is consumed
                if (!valid_q || sampleReady) begin
                    capture = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
`ifdef COSO_TIMEOUT_EN
        tmo_d     = tmo_q;
        tmo_err_d = tmo_err_q;
        if (state_q == S_CLEAR) begin
            tmo_d = TMO_LOAD;
        end else if (state_q == S_ARM || state_q == S_COUNT) begin
            if (tmo_q == 20'd0) begin
                state_d   = S_IDLE;
                tmo_err_d = 1'b1;
            end else begin
                tmo_d = tmo_q - 20'd1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= S_IDLE;
            beat_meta_q <= 1'b0;
            beat_sync_q <= 1'b0;
            beat_prev_q <= 1'b0;
            clr_cnt_q   <= 1'b0;
            settle_q    <= 8'd0;
            sample_q    <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_meta_q <= beat;
            beat_sync_q <= beat_meta_q;
            beat_prev_q <= beat_sync_q;
            clr_cnt_q   <= clr_cnt_d;
            settle_q    <= settle_d;
            if (capture) begin
                sample_q <= cnt;
                valid_q  <= 1'b1;
            end else if (valid_q && sampleReady) begin
                valid_q  <= 1'b0;
            end
        end
    end

`ifdef COSO_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (clr) begin
            tmo_q     <= 20'd0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_q     <= tmo_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    assign timeoutErr = tmo_err_q;
`else
    // No timer: the flag is constant low for every legal timeoutCycles
    assign timeoutErr = 1'b0 & (timeoutCycles == 0);
`endif

    assign sampleValid = valid_q;
    assign sample      = sample_q;
    assign rndBit      = sample_q[0];

endmodule

// File: tb/tb_coso_count_ctrl.sv
// Bench for coso_count_ctrl: beat generated in step with clk so every window is exactly one period.
module tb_coso_count_ctrl;
    localparam int W      = 16;
    localparam int SETTLE = 4;

    logic clk = 1'b0;
    logic clr, start, beat, ready;

    logic [W-1:0] m16, sample16;
    logic         cntClr16, cntEn16, busy16, valid16, rnd16, terr16;
    logic [3:0]   m4, sample4;
    logic         cntClr4, cntEn4, busy4, valid4, rnd4, terr4;

    always #5 clk = ~clk;

    coso_count_ctrl #(.width(W), .settleCycles(SETTLE), .timeoutCycles(65535)) dut (
        .clk(clk), .clr(clr), .start(start), .beat(beat), .cnt(m16),
        .cntClr(cntClr16), .cntEn(cntEn16), .busy(busy16), .sampleValid(valid16),
        .sampleReady(ready), .sample(sample16), .rndBit(rnd16), .timeoutErr(terr16));

    coso_count_ctrl #(.width(4), .settleCycles(SETTLE), .timeoutCycles(65535)) dut4 (
        .clk(clk), .clr(clr), .start(start), .beat(beat), .cnt(m4),
        .cntClr(cntClr4), .cntEn(cntEn4), .busy(busy4), .sampleValid(valid4),
        .sampleReady(ready), .sample(sample4), .rndBit(rnd4), .timeoutErr(terr4));

    always @(posedge clk) begin
        if (cntClr16) m16 <= '0; else if (cntEn16) m16 <= m16 + 1'b1;
        if (cntClr4)  m4  <= '0; else if (cntEn4)  m4  <= m4 + 1'b1;
    end

`ifdef COSO_TIMEOUT_EN
    logic [W-1:0] mt, samplet;
    logic         start_t, beat_t, beat_t_en;
    logic         cntClrt, cntEnt, busyt, validt, rndt, terrt;
    assign beat_t = beat_t_en & beat;

    coso_count_ctrl #(.width(W), .settleCycles(SETTLE), .timeoutCycles(100)) dut_t (
        .clk(clk), .clr(clr), .start(start_t), .beat(beat_t), .cnt(mt),
        .cntClr(cntClrt), .cntEn(cntEnt), .busy(busyt), .sampleValid(validt),
        .sampleReady(ready), .sample(samplet), .rndBit(rndt), .timeoutErr(terrt));

    always @(posedge clk) begin
        if (cntClrt) mt <= '0; else if (cntEnt) mt <= mt + 1'b1;
    end
`endif

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // beat generator, phase advanced just after each clk edge
    int beat_per = 40;
    bit beat_run = 1'b0;
    int ph = 0;
    initial begin
        beat = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (beat_run) begin
                ph   = (ph + 1) % beat_per;
                beat = (ph < beat_per / 2);
            end else begin
                ph   = 0;
                beat = 1'b0;
            end
        end
    end

    // scoreboard and pulse-length monitor
    logic [W-1:0] exp_q[$];
    int cyc = 0;
    int clr_run = 0, clr_last = 0, en_run = 0, en_last = 0, v_run = 0, v_last = 0;
    int en_fall_cyc = 0, gap_last = 0;
    bit valid_seen = 1'b0;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (cntClr16) clr_run++;
        else if (clr_run != 0) begin clr_last = clr_run; clr_run = 0; end
        if (cntEn16) en_run++;
        else if (en_run != 0) begin en_last = en_run; en_run = 0; en_fall_cyc = cyc; end
        if (valid16) begin
            if (v_run == 0) gap_last = cyc - en_fall_cyc;
            v_run++;
            valid_seen = 1'b1;
        end else if (v_run != 0) begin
            v_last = v_run;
            v_run  = 0;
        end
        if (valid16 && ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_sample", 32'(sample16), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("sample", 32'(sample16), 32'(e));
                check("rndBit", 32'(rnd16), 32'(e[0]));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        while (busy16 && k < budget) begin tick(1); k++; end
        check(name, 32'(busy16), 32'd0);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin tick(1); k++; end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    typedef struct {
        int           period;
        logic [W-1:0] exp_sample;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int k;
        vecs[0] = '{40, 16'd40};
        vecs[1] = '{23, 16'd23};
        vecs[2] = '{8,  16'd8};
        vecs[3] = '{57, 16'd57};
        vecs[4] = '{13, 16'd13};

        clr = 1'b1; start = 1'b0; ready = 1'b1;
`ifdef COSO_TIMEOUT_EN
        start_t = 1'b0; beat_t_en = 1'b0;
`endif
        tick(3);
        check("rst_cntClr", 32'(cntClr16), 0);
        check("rst_cntEn",  32'(cntEn16),  0);
        check("rst_busy",   32'(busy16),   0);
        check("rst_valid",  32'(valid16),  0);
        check("rst_sample", 32'(sample16), 0);
        check("rst_rndBit", 32'(rnd16),    0);
        check("rst_timeoutErr", 32'(terr16), 0);
        clr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("idle_busy_en", {30'd0, busy16, cntEn16}, 0);
        end

        // nominal measurements, ready held high
        beat_run = 1'b1;
        foreach (vecs[i]) begin
            beat_per = vecs[i].period;
            tick(2 * vecs[i].period);
            pulse_start();
            exp_q.push_back(vecs[i].exp_sample);
            wait_idle("nominal_done", 4 * vecs[i].period + 40);
            wait_drain("nominal_drain", 20);
            tick(2);
            check("cntClr_len", 32'(clr_last), 2);
            check("cntEn_len",  32'(en_last),  32'(vecs[i].period));
            check("valid_gap",  32'(gap_last), 32'(SETTLE + 1));
            check("valid_len",  32'(v_last),   1);
        end

        // backpressure: two measurements while downstream stalls
        ready    = 1'b0;
        beat_per = 30;
        tick(60);
        pulse_start();
        exp_q.push_back(16'd30);
        wait_idle("bp_first_done", 160);
        check("bp_first_valid",  32'(valid16),  1);
        check("bp_first_sample", 32'(sample16), 30);
        beat_per = 14;
        tick(28);
        pulse_start();
        exp_q.push_back(16'd14);
        for (int i = 0; i < 8; i++) begin
            tick(10);
            check("bp_hold_sample", 32'(sample16), 30);
        end
        check("bp_stall_busy",  32'(busy16),  1);
        check("bp_stall_valid", 32'(valid16), 1);
        ready = 1'b1;
        wait_drain("bp_drain", 10);
        wait_idle("bp_second_done", 10);

        // wrap: 19 increments on a 4-bit counter
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        beat_per = 19;
        tick(38);
        pulse_start();
        exp_q.push_back(16'd19);
        k = 0;
        while (busy4 && k < 120) begin tick(1); k++; end
        check("wrap_done",   32'(busy4),   0);
        check("wrap_valid",  32'(valid4),  1);
        check("wrap_sample", 32'(sample4), 3);
        check("wrap_rndBit", 32'(rnd4),    1);
        wait_drain("wrap_drain", 20);

        // clr in the middle of COUNT
        beat_per = 40;
        tick(80);
        pulse_start();
        k = 0;
        while (!cntEn16 && k < 100) begin tick(1); k++; end
        check("midrst_counting", 32'(cntEn16), 1);
        tick(10);
        valid_seen = 1'b0;
        clr = 1'b1;
        tick(1);
        check("midrst_cntEn", 32'(cntEn16), 0);
        check("midrst_busy",  32'(busy16),  0);
        check("midrst_valid", 32'(valid16), 0);
        clr = 1'b0;
        tick(150);
        check("midrst_no_sample", 32'(valid_seen), 0);
        check("midrst_still_idle", 32'(busy16), 0);

`ifdef COSO_TIMEOUT_EN
        // stuck beat: 2 CLEAR cycles plus 100 in ARM before abort
        start_t = 1'b1;
        tick(1);
        start_t = 1'b0;
        k = 0;
        while (busyt && k < 300) begin tick(1); k++; end
        check("tmo_latency", 32'(k), 102);
        check("tmo_err",   32'(terrt),  1);
        check("tmo_busy",  32'(busyt),  0);
        check("tmo_valid", 32'(validt), 0);
        beat_t_en = 1'b1;
        beat_per  = 20;
        tick(40);
        start_t = 1'b1;
        tick(1);
        start_t = 1'b0;
        k = 0;
        while (busyt && k < 150) begin tick(1); k++; end
        check("tmo_good_valid",  32'(validt),  1);
        check("tmo_good_sample", 32'(samplet), 20);
        check("tmo_sticky",      32'(terrt),   1);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check("tmo_cleared", 32'(terrt), 0);
`else
        check("no_timer_err", 32'(terr16), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", compared);
        $fatal(1, "watchdog");
    end
endmodule
